// File: rtl/lsu_pkg.sv
// Shared constants and FSM state type for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int DMEM_WORDS_DEFAULT = 256;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RMW_RD,
    S_RMW_MRG,
    S_RMW_WR,
    S_ERR
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane logic: load extract + extend, and store lane merge into a read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'h0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'h0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

  // Only SB/SH reach the merge path; anything else passes the read word through.
  always_comb begin
    merge_data_o = rdata_i;
    if (funct3_i == F3_B) begin
      case (addr_lo_i)
        2'd0:    merge_data_o[7:0]   = wdata_i[7:0];
        2'd1:    merge_data_o[15:8]  = wdata_i[7:0];
        2'd2:    merge_data_o[23:16] = wdata_i[7:0];
        default: merge_data_o[31:24] = wdata_i[7:0];
      endcase
    end else if (funct3_i == F3_H) begin
      if (addr_lo_i[1]) merge_data_o[31:16] = wdata_i[15:0];
      else              merge_data_o[15:0]  = wdata_i[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: word-aligned data_memory accesses, sub-word loads, RMW sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = DMEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_WORDS);

  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // req_ready is high only in IDLE and upstream holds its request until then.
  lsu_state_e  state_q, state_d;
  logic [31:0] lat_addr_q, lat_wdata_q, merge_q, merge_d;
  logic [2:0]  lat_f3_q;
  logic        lat_store_q;
  logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        accept, acc_err;
  logic        is_half, is_word, misalign, out_of_range, bad_f3;
  logic [31:0] load_data, merge_data;

  lsu_align u_align (
    .funct3_i     (lat_f3_q),
    .addr_lo_i    (lat_addr_q[1:0]),
    .rdata_i      (mem_read_data),
    .wdata_i      (lat_wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_comb begin
    is_half      = (req_funct3 == F3_H) || (req_funct3 == F3_HU);
    is_word      = (req_funct3 == F3_W);
    misalign     = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    out_of_range = {2'b00, req_addr[31:2]} >= DMEM_LIMIT;
    bad_f3       = req_is_store ? !(req_funct3 inside {F3_B, F3_H, F3_W})
                                : (req_funct3 inside {3'b011, 3'b110, 3'b111});
    acc_err      = misalign || out_of_range || bad_f3;
    accept       = req_valid && req_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_f3_q     <= '0;
      lat_store_q  <= 1'b0;
      merge_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      merge_q      <= merge_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      if (accept) begin
        lat_addr_q  <= req_addr;
        lat_wdata_q <= req_wdata;
        lat_f3_q    <= req_funct3;
        lat_store_q <= req_is_store;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (acc_err)                 state_d = S_ERR;
          else if (!req_is_store)      state_d = S_RD;
          else if (req_funct3 == F3_W) state_d = S_WR;
          else                         state_d = S_RMW_RD;
        end
      end
      S_RD:      state_d = S_CAP;
      S_CAP:     state_d = S_IDLE;
      S_WR:      state_d = S_IDLE;
      S_RMW_RD:  state_d = S_RMW_MRG;
      S_RMW_MRG: state_d = S_RMW_WR;
      S_RMW_WR:  state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Read data is only valid in the cycle after a read strobe, so CAP/RMW_MRG sample it directly.
  always_comb begin
    req_ready      = (state_q == S_IDLE);
    mem_read_en    = (state_q == S_RD) || (state_q == S_RMW_RD);
    mem_write_en   = (state_q == S_WR) || (state_q == S_RMW_WR);
    mem_write_data = '0;
    if (state_q == S_WR)     mem_write_data = lat_wdata_q;
    if (state_q == S_RMW_WR) mem_write_data = merge_q;
    mem_byte_enable = {4{mem_write_en}};
    mem_addr        = {lat_addr_q[31:2], 2'b00};
    merge_d         = (state_q == S_RMW_MRG) ? merge_data : merge_q;
    resp_valid_d    = (state_q == S_CAP) || (state_q == S_WR) ||
                      (state_q == S_RMW_WR) || (state_q == S_ERR);
    resp_err_d      = (state_q == S_ERR);
    resp_rdata_d    = (state_q == S_CAP && !lat_store_q) ? load_data : '0;
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: data_memory model, vector table, corner sequences, random ops vs reference memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_read_data = '0;

  always #5 clk = ~clk;

  load_store_unit #(.DMEM_WORDS(256)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read_en     (mem_read_en),
    .mem_byte_enable (mem_byte_enable),
    .mem_read_data   (mem_read_data)
  );

  // data_memory model: synchronous read, 0 when not reading, full-word writes
  logic [31:0] mem [0:255] = '{default: 32'hDEADBEEF};
  always @(posedge clk) begin
    if (mem_read_en) mem_read_data <= mem[mem_addr[9:2]];
    else             mem_read_data <= '0;
    if (mem_write_en) mem[mem_addr[9:2]] <= mem_write_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
    logic [1:0]  n_rd;
    logic [1:0]  n_wr;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int rd_cnt = 0;
  int wr_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read_en || mem_write_en) begin
        check("strobe_excl", {31'b0, mem_read_en && mem_write_en}, 32'd0);
        check("byte_enable", {28'b0, mem_byte_enable}, mem_write_en ? 32'hF : 32'h0);
        if (exp_q.size() > 0) check("mem_addr", mem_addr, {exp_q[0].addr[31:2], 2'b00});
        if (mem_read_en)  rd_cnt++;
        if (mem_write_en) wr_cnt++;
      end else begin
        check("byte_enable_idle", {28'b0, mem_byte_enable}, 32'h0);
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_resp: got resp_valid=1 rdata %h expected no response", resp_rdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_rdata", resp_rdata, mon_e.rdata);
          check("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
          check("latency_cycle", cyc, mon_e.cyc);
          check("read_strobes", rd_cnt, {30'b0, mon_e.n_rd});
          check("write_strobes", wr_cnt, {30'b0, mon_e.n_wr});
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee,
                      input int lat, input int nrd, input int nwr, input bit push,
                      output logic resp_at_accept);
    int guard = 0;
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    resp_at_accept = resp_valid;
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready=0 for 20 cycles expected 1");
    end else if (push) begin
      exp_q.push_back(exp_t'{cyc: 32'(cyc + lat), rdata: er, addr: a, err: ee,
                             n_rd: 2'(nrd), n_wr: 2'(nwr)});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } vec_t;

  function automatic vec_t v_ld(logic [2:0] f3, logic [31:0] a, logic [31:0] r);
    return '{1'b0, f3, a, 32'h0, r, 1'b0, 3, 1, 0};
  endfunction
  function automatic vec_t v_sw(logic [31:0] a, logic [31:0] wd);
    return '{1'b1, F3_W, a, wd, 32'h0, 1'b0, 2, 0, 1};
  endfunction
  function automatic vec_t v_sub(logic [2:0] f3, logic [31:0] a, logic [31:0] wd);
    return '{1'b1, f3, a, wd, 32'h0, 1'b0, 4, 1, 1};
  endfunction
  function automatic vec_t v_err(logic st, logic [2:0] f3, logic [31:0] a);
    return '{st, f3, a, 32'h12345678, 32'h0, 1'b1, 2, 0, 0};
  endfunction

  // ---------------- reference model for random ops ----------------
  logic [31:0] ref_mem [0:255] = '{default: 32'hDEADBEEF};

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      F3_B:    return {{24{s[7]}}, s[7:0]};
      F3_BU:   return {24'h0, s[7:0]};
      F3_H:    return {{16{s[15]}}, s[15:0]};
      F3_HU:   return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(logic [31:0] w, logic [2:0] f3, logic [1:0] off,
                                            logic [31:0] wd);
    logic [31:0] mask;
    if (f3 == F3_W) return wd;
    mask = ((f3 == F3_B) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * off);
    return (w & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  initial begin
    vec_t tbl[25];
    logic acc_r;
    logic [2:0] lf3 [5];

    tbl[0]  = v_ld(F3_B,  32'h3,   32'hFFFF_FFDE);
    tbl[1]  = v_ld(F3_BU, 32'h3,   32'h0000_00DE);
    tbl[2]  = v_ld(F3_HU, 32'h0,   32'h0000_BEEF);
    tbl[3]  = v_ld(F3_H,  32'h2,   32'hFFFF_DEAD);
    tbl[4]  = v_ld(F3_W,  32'h0,   32'hDEAD_BEEF);
    tbl[5]  = v_sub(F3_H, 32'h6,   32'h0000_1234);
    tbl[6]  = v_ld(F3_W,  32'h4,   32'h1234_BEEF);
    tbl[7]  = v_sw(32'h8, 32'hCAFE_F00D);
    tbl[8]  = v_ld(F3_W,  32'h8,   32'hCAFE_F00D);
    tbl[9]  = v_sub(F3_B, 32'h9,   32'h7777_77AA);
    tbl[10] = v_ld(F3_B,  32'h9,   32'hFFFF_FFAA);
    tbl[11] = v_ld(F3_W,  32'h8,   32'hCAFE_AA0D);
    tbl[12] = v_ld(F3_HU, 32'hA,   32'h0000_CAFE);
    tbl[13] = v_ld(F3_B,  32'h8,   32'h0000_000D);
    tbl[14] = v_ld(F3_H,  32'h3FE, 32'hFFFF_DEAD);
    tbl[15] = v_err(1'b0, F3_W, 32'h2);
    tbl[16] = v_err(1'b1, F3_H, 32'h5);
    tbl[17] = v_err(1'b0, F3_W, 32'h400);
    tbl[18] = v_err(1'b0, 3'b011, 32'h0);
    tbl[19] = v_err(1'b1, F3_BU, 32'h0);
    tbl[20] = v_err(1'b0, F3_H, 32'h1);
    tbl[21] = v_ld(F3_BU, 32'h3FF, 32'h0000_00DE);
    tbl[22] = v_sub(F3_B, 32'h3FC, 32'h0000_0011);
    tbl[23] = v_ld(F3_W,  32'h3FC, 32'hDEAD_BE11);
    tbl[24] = v_err(1'b1, F3_W, 32'hFFFF_FFFC);

    lf3 = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_mem_strobes", {30'b0, mem_read_en, mem_write_en}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      send(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rdata, tbl[i].err,
           tbl[i].lat, tbl[i].nrd, tbl[i].nwr, 1'b1, acc_r);
    end
    drain();
    check("sh_word1_contents", mem[1], 32'h1234_BEEF);

    // back-to-back: second request accepted in the cycle the first responds
    send(1'b1, F3_W, 32'h10, 32'h1357_2468, 32'h0, 1'b0, 2, 0, 1, 1'b1, acc_r);
    send(1'b0, F3_W, 32'h10, 32'h0, 32'h1357_2468, 1'b0, 3, 1, 0, 1'b1, acc_r);
    check("b2b_accept_in_resp_cycle", {31'b0, acc_r}, 32'd1);
    drain();

    // reset during RMW_MRG of SB 0x1 aborts the write
    send(1'b1, F3_B, 32'h1, 32'h0000_0055, 32'h0, 1'b0, 4, 1, 1, 1'b0, acc_r);
    @(negedge clk);  // RMW_RD
    @(negedge clk);  // RMW_MRG
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'd0);
    check("abort_resp_err", {31'b0, resp_err}, 32'd0);
    check("abort_mem_strobes", {30'b0, mem_read_en, mem_write_en}, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_mem_wdata", mem_write_data, 32'd0);
    check("abort_byte_enable", {28'b0, mem_byte_enable}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("abort_no_write", wr_cnt, 32'd0);
    check("abort_word0_intact", mem[0], 32'hDEAD_BEEF);
    rd_cnt = 0;
    wr_cnt = 0;
    send(1'b0, F3_W, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 1, 0, 1'b1, acc_r);
    drain();

    // random ops on words 32..63 against the reference memory
    for (int i = 0; i < 40; i++) begin
      int w;
      int op;
      logic [1:0] off;
      logic [2:0] f3;
      logic [31:0] a, wd;
      w  = $urandom_range(63, 32);
      op = $urandom_range(3, 0);
      wd = $urandom;
      case (op)
        0: begin f3 = F3_W; off = 2'd0; end
        1: begin f3 = F3_H; off = {1'($urandom_range(1, 0)), 1'b0}; end
        2: begin f3 = F3_B; off = 2'($urandom_range(3, 0)); end
        default: begin
          f3 = lf3[$urandom_range(4, 0)];
          if (f3 == F3_W) off = 2'd0;
          else if (f3 == F3_H || f3 == F3_HU) off = {1'($urandom_range(1, 0)), 1'b0};
          else off = 2'($urandom_range(3, 0));
        end
      endcase
      a = {22'h0, 8'(w), off};
      if (op == 3) begin
        send(1'b0, f3, a, 32'h0, ref_load(ref_mem[w], f3, off), 1'b0, 3, 1, 0, 1'b1, acc_r);
      end else begin
        send(1'b1, f3, a, wd, 32'h0, 1'b0, (f3 == F3_W) ? 2 : 4,
             (f3 == F3_W) ? 0 : 1, 1, 1'b1, acc_r);
        ref_mem[w] = ref_store(ref_mem[w], f3, off, wd);
      end
    end
    drain();
    for (int w = 32; w < 64; w++) check("rand_mem_final", mem[w], ref_mem[w]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion by 200000 expected earlier");
    $fatal(1, "timeout");
  end

endmodule
